// File: rtl/mcpu_pkg.sv
// Shared definitions for the multi-cycle core: instruction fields, opcodes, ALU commands,
// FSM states and the decode bundle. Branch support is selected with MCPU_BRANCH_EN.
package mcpu_pkg;

    localparam int unsigned OpcLsb   = 0;
    localparam int unsigned OpcMsb   = 5;
    localparam int unsigned RdLsb    = 6;
    localparam int unsigned RdMsb    = 10;
    localparam int unsigned Rs1Lsb   = 11;
    localparam int unsigned Rs1Msb   = 15;
    localparam int unsigned Rs2Lsb   = 16;
    localparam int unsigned Rs2Msb   = 20;
    localparam int unsigned FunctLsb = 21;
    localparam int unsigned FunctMsb = 31;
    localparam int unsigned ImmLsb   = 16;
    localparam int unsigned ImmMsb   = 31;

    localparam logic [5:0] OpcNop     = 6'd0;
    localparam logic [5:0] OpcCompute = 6'd1;
    localparam logic [5:0] OpcJmp     = 6'd2;
    localparam logic [5:0] OpcAddi    = 6'd3;
    localparam logic [5:0] OpcSubi    = 6'd4;
    localparam logic [5:0] OpcLw      = 6'd5;
    localparam logic [5:0] OpcSw      = 6'd6;
    localparam logic [5:0] OpcBeq     = 6'd7;

    localparam logic [10:0] FnAddu = 11'd0;
    localparam logic [10:0] FnSubu = 11'd1;
    localparam logic [10:0] FnBand = 11'd2;
    localparam logic [10:0] FnBor  = 11'd3;
    localparam logic [10:0] FnBxor = 11'd4;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;

    typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb} state_e;

    typedef enum logic [1:0] {MemNone, MemLoad, MemStore} mem_e;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       imm_sel;
        logic       rf_we;
        mem_e       mem;
        logic       jump;
        logic       branch;
        logic       illegal;
    } dec_t;

endpackage

// File: rtl/mcpu_decoder.sv
// Combinational instruction decode for mcpu. Opcode 7 decodes as BEQ only when
// MCPU_BRANCH_EN is defined; otherwise it is reported illegal.
module mcpu_decoder
    import mcpu_pkg::*;
(
    input  logic [5:0]  opcode_i,
    input  logic [10:0] funct_i,
    output dec_t        dec_o
);

    always_comb begin
        dec_o = '{alu_op: ALU_ADD, imm_sel: 1'b0, rf_we: 1'b0, mem: MemNone,
                  jump: 1'b0, branch: 1'b0, illegal: 1'b0};
        case (opcode_i)
            OpcNop: ;
            OpcCompute: begin
                dec_o.rf_we = 1'b1;
                case (funct_i)
                    FnAddu:  dec_o.alu_op = ALU_ADD;
                    FnSubu:  dec_o.alu_op = ALU_SUB;
                    FnBand:  dec_o.alu_op = ALU_AND;
                    FnBor:   dec_o.alu_op = ALU_OR;
                    FnBxor:  dec_o.alu_op = ALU_XOR;
                    default: begin
                        dec_o.rf_we   = 1'b0;
                        dec_o.illegal = 1'b1;
                    end
                endcase
            end
            OpcJmp: dec_o.jump = 1'b1;
            OpcAddi: begin
                dec_o.imm_sel = 1'b1;
                dec_o.rf_we   = 1'b1;
            end
            OpcSubi: begin
                dec_o.alu_op  = ALU_SUB;
                dec_o.imm_sel = 1'b1;
                dec_o.rf_we   = 1'b1;
            end
            OpcLw: begin
                dec_o.imm_sel = 1'b1;
                dec_o.rf_we   = 1'b1;
                dec_o.mem     = MemLoad;
            end
            OpcSw: begin
                dec_o.imm_sel = 1'b1;
                dec_o.mem     = MemStore;
            end
`ifdef MCPU_BRANCH_EN
            OpcBeq: dec_o.branch = 1'b1;
`endif
            default: dec_o.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mcpu.sv
// Multi-cycle core: FETCH/DECODE/EXEC/MEM/WB with req/ack memory ports and r0 hardwired to 0.
// BEQ (opcode 7) is built only when MCPU_BRANCH_EN is defined.
module mcpu
    import mcpu_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            reset_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_ack_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            retire_o,
    output logic            illegal_o
);

    state_e          state_q, state_d;
    logic            run_q;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] op_a_q, op_a_d, op_b_q, op_b_d, st_q, st_d, res_q, res_d;
    logic [XLEN-1:0] rf_q [1:NREGS-1];
    logic            rf_we, imem_req, dmem_req, dmem_we, retire, illegal;
    dec_t            dec;
    logic [4:0]      rd_sel, rs1_sel, rs2_sel;
    logic [15:0]     imm;
    logic [XLEN-1:0] rd_val, rs1_val, rs2_val, imm_z, jmp_tgt, pc_plus4, alu_res;

    assign rd_sel   = ir_q[RdMsb:RdLsb];
    assign rs1_sel  = ir_q[Rs1Msb:Rs1Lsb];
    assign rs2_sel  = ir_q[Rs2Msb:Rs2Lsb];
    assign imm      = ir_q[ImmMsb:ImmLsb];
    assign imm_z    = XLEN'(imm);
    assign jmp_tgt  = XLEN'({imm, 2'b00});
    assign pc_plus4 = pc_q + XLEN'(4);

`ifdef MCPU_BRANCH_EN
    logic               take_q, take_d;
    logic signed [17:0] br_off;
    logic [XLEN-1:0]    br_tgt;
    assign br_off = {imm, 2'b00};
    assign br_tgt = pc_plus4 + XLEN'(br_off);
`endif

    mcpu_decoder u_decoder (
        .opcode_i (ir_q[OpcMsb:OpcLsb]),
        .funct_i  (ir_q[FunctMsb:FunctLsb]),
        .dec_o    (dec)
    );

    // Selectors of 0 or >= NREGS fall through to the zero default.
    always_comb begin
        rd_val  = '0;
        rs1_val = '0;
        rs2_val = '0;
        for (int unsigned i = 1; i < NREGS; i++) begin
            if (rd_sel == i[4:0])  rd_val  = rf_q[i];
            if (rs1_sel == i[4:0]) rs1_val = rf_q[i];
            if (rs2_sel == i[4:0]) rs2_val = rf_q[i];
        end
    end

    always_comb begin
        case (dec.alu_op)
            ALU_SUB: alu_res = op_a_q - op_b_q;
            ALU_AND: alu_res = op_a_q & op_b_q;
            ALU_OR:  alu_res = op_a_q | op_b_q;
            ALU_XOR: alu_res = op_a_q ^ op_b_q;
            default: alu_res = op_a_q + op_b_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        st_d     = st_q;
        res_d    = res_q;
        rf_we    = 1'b0;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        retire   = 1'b0;
        illegal  = 1'b0;
`ifdef MCPU_BRANCH_EN
        take_d   = take_q;
`endif
        case (state_q)
            StFetch: begin
                imem_req = run_q;
                if (run_q && imem_ack_i) begin
                    ir_d    = imem_rdata_i;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                op_a_d  = rs1_val;
                op_b_d  = dec.imm_sel ? imm_z : rs2_val;
                st_d    = rd_val;
                state_d = StExec;
            end
            StExec: begin
                res_d   = alu_res;
`ifdef MCPU_BRANCH_EN
                take_d  = dec.branch && (st_q == op_a_q);
`endif
                state_d = (dec.mem != MemNone) ? StMem : StWb;
            end
            StMem: begin
                dmem_req = 1'b1;
                dmem_we  = (dec.mem == MemStore);
                if (dmem_ack_i) begin
                    if (dec.mem == MemLoad) res_d = dmem_rdata_i;
                    state_d = StWb;
                end
            end
            StWb: begin
                rf_we   = dec.rf_we;
                retire  = 1'b1;
                illegal = dec.illegal;
                if (dec.jump) begin
                    pc_d = jmp_tgt;
`ifdef MCPU_BRANCH_EN
                end else if (take_q) begin
                    pc_d = br_tgt;
`endif
                end else begin
                    pc_d = pc_plus4;
                end
                state_d = StFetch;
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StFetch;
            run_q   <= 1'b0;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            st_q    <= '0;
            res_q   <= '0;
`ifdef MCPU_BRANCH_EN
            take_q  <= 1'b0;
`endif
            for (int unsigned i = 1; i < NREGS; i++) rf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            st_q    <= st_d;
            res_q   <= res_d;
`ifdef MCPU_BRANCH_EN
            take_q  <= take_d;
`endif
            for (int unsigned i = 1; i < NREGS; i++) begin
                if (rf_we && rd_sel == i[4:0]) rf_q[i] <= res_q;
            end
        end
    end

    // Reset forces every output low regardless of internal state.
    assign imem_req_o   = imem_req & ~reset_i;
    assign imem_addr_o  = reset_i ? '0 : pc_q;
    assign dmem_req_o   = dmem_req & ~reset_i;
    assign dmem_we_o    = dmem_we & ~reset_i;
    assign dmem_addr_o  = reset_i ? '0 : res_q;
    assign dmem_wdata_o = reset_i ? '0 : st_q;
    assign retire_o     = retire & ~reset_i;
    assign illegal_o    = illegal & ~reset_i;

endmodule

// File: tb/tb_mcpu.sv
// Scoreboard bench for mcpu: expected fetches, data accesses and retires are queued by the
// stimulus and popped by a monitor as the core presents them.
module tb_mcpu;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, retire, illegal;
    logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;

    logic [31:0] rom [128];
    logic [31:0] ram [64];
    int unsigned imem_wait = 0, dmem_wait = 3;
    int unsigned icnt = 0, dcnt = 0;
    logic        force_iack = 1'b0;

    typedef struct {
        logic ill;
        int   interval;
    } ret_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_wd;
    } dm_t;

    logic [31:0] fetch_q [$];
    ret_t        ret_q [$];
    dm_t         dm_q [$];
    int          checks = 0, errors = 0;
    int          cyc = 0;

    mcpu dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .imem_ack_i   (imem_ack),
        .imem_rdata_i (imem_rdata),
        .dmem_req_o   (dmem_req),
        .dmem_we_o    (dmem_we),
        .dmem_addr_o  (dmem_addr),
        .dmem_wdata_o (dmem_wdata),
        .dmem_ack_i   (dmem_ack),
        .dmem_rdata_i (dmem_rdata),
        .retire_o     (retire),
        .illegal_o    (illegal)
    );

    always #5 clk = ~clk;

    assign imem_ack   = (imem_req && icnt == imem_wait) || force_iack;
    assign imem_rdata = rom[imem_addr[8:2]];
    assign dmem_ack   = dmem_req && dcnt == dmem_wait;
    assign dmem_rdata = ram[dmem_addr[7:2]];

    always @(posedge clk) begin
        icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
        dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
        cyc  <= reset ? 0 : cyc + 1;
        if (dmem_req && dmem_ack && dmem_we) ram[dmem_addr[7:2]] <= dmem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [15:0] imm);
        return {imm, rs1, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [10:0] funct);
        return {funct, rs2, rs1, rd, op};
    endfunction

    task automatic put(input logic [31:0] addr, input logic [31:0] word);
        rom[addr[8:2]] = word;
    endtask

    task automatic push_ret(input logic ill, input int iv);
        ret_t r;
        r.ill      = ill;
        r.interval = iv;
        ret_q.push_back(r);
    endtask

    task automatic push_dm(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic chk);
        dm_t d;
        d.we     = we;
        d.addr   = addr;
        d.wdata  = wd;
        d.chk_wd = chk;
        dm_q.push_back(d);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((fetch_q.size() + ret_q.size() + dm_q.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_remaining", fetch_q.size() + ret_q.size() + dm_q.size(), 0);
    endtask

    // Monitor: pops one expectation per new fetch, data access and retire.
    initial begin
        logic        prev_ireq = 1'b0, prev_iack = 1'b0, prev_dreq = 1'b0, prev_dack = 1'b0;
        logic        dstable = 1'b1;
        logic [31:0] a0 = '0, w0 = '0;
        logic        we0 = 1'b0;
        int          dlen = 0, last_ret = 0;
        dm_t         cur;
        ret_t        r;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_ireq = 1'b0;
                prev_iack = 1'b0;
                prev_dreq = 1'b0;
                prev_dack = 1'b0;
                last_ret  = 0;
            end else begin
                if (imem_req && (!prev_ireq || prev_iack) && fetch_q.size() > 0)
                    check("fetch_addr", imem_addr, fetch_q.pop_front());
                if (dmem_req) begin
                    if (!prev_dreq || prev_dack) begin
                        if (dm_q.size() > 0) begin
                            cur = dm_q.pop_front();
                            check("dmem_we", {31'b0, dmem_we}, {31'b0, cur.we});
                            check("dmem_addr", dmem_addr, cur.addr);
                            if (cur.chk_wd) check("dmem_wdata", dmem_wdata, cur.wdata);
                        end else begin
                            checks++;
                            errors++;
                            $display("FAIL dmem_unexpected: got addr %h expected no access",
                                     dmem_addr);
                        end
                        dlen    = 1;
                        dstable = 1'b1;
                        a0      = dmem_addr;
                        w0      = dmem_wdata;
                        we0     = dmem_we;
                    end else begin
                        dlen++;
                        if (dmem_addr !== a0 || dmem_wdata !== w0 || dmem_we !== we0)
                            dstable = 1'b0;
                    end
                    if (dmem_ack) begin
                        check("dmem_req_len", dlen, 4);
                        check("dmem_stable", {31'b0, dstable}, 32'd1);
                    end
                end
                if (illegal) check("illegal_with_retire", {31'b0, retire}, 32'd1);
                if (retire) begin
                    if (ret_q.size() > 0) begin
                        r = ret_q.pop_front();
                        check("illegal", {31'b0, illegal}, {31'b0, r.ill});
                        check("retire_interval", cyc - last_ret, r.interval);
                    end
                    last_ret = cyc;
                end
                prev_ireq = imem_req;
                prev_iack = imem_ack;
                prev_dreq = dmem_req;
                prev_dack = dmem_ack;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset = 1'b1;
        for (int i = 0; i < 128; i++) rom[i] = '0;
        for (int i = 0; i < 64; i++) ram[i] = '0;
        put(32'h00, enc_i(6'd3, 5'd1, 5'd0, 16'd5));          // ADDI r1,r0,5
        put(32'h04, enc_i(6'd3, 5'd2, 5'd0, 16'd7));          // ADDI r2,r0,7
        put(32'h08, enc_r(6'd1, 5'd3, 5'd1, 5'd2, 11'd0));    // ADD r3,r1,r2
        put(32'h0C, enc_i(6'd6, 5'd3, 5'd0, 16'h10));         // SW r3,0x10
        put(32'h10, enc_i(6'd5, 5'd4, 5'd0, 16'h10));         // LW r4,0x10
        put(32'h14, enc_i(6'd6, 5'd4, 5'd0, 16'h14));         // SW r4,0x14
        put(32'h18, enc_i(6'd4, 5'd1, 5'd0, 16'd1));          // SUBI r1,r0,1
        put(32'h1C, enc_i(6'd6, 5'd1, 5'd0, 16'h18));         // SW r1,0x18
        put(32'h20, enc_i(6'd3, 5'd0, 5'd0, 16'd9));          // ADDI r0,r0,9
        put(32'h24, enc_i(6'd6, 5'd0, 5'd0, 16'h1C));         // SW r0,0x1C
        put(32'h28, enc_i(6'd3, 5'd7, 5'd0, 16'd1));          // ADDI r7,r0,1
        put(32'h2C, enc_i(6'd3, 5'd6, 5'd6, 16'd1));          // ADDI r6,r6,1
        put(32'h30, enc_i(6'd7, 5'd6, 5'd7, 16'hFFFE));       // BEQ r6,r7,-2
        put(32'h34, enc_i(6'd6, 5'd6, 5'd0, 16'h20));         // SW r6,0x20
        put(32'h38, 32'h0000_003F);                           // undefined opcode
        put(32'h3C, enc_r(6'd1, 5'd3, 5'd1, 5'd2, 11'd9));    // COMPUTE funct 9
        put(32'h40, enc_i(6'd6, 5'd3, 5'd0, 16'h24));         // SW r3,0x24
        put(32'h44, enc_i(6'd2, 5'd0, 5'd0, 16'h40));         // JMP 0x100
        put(32'h100, enc_r(6'd1, 5'd5, 5'd2, 5'd1, 11'd1));   // SUB r5,r2,r1
        put(32'h104, enc_r(6'd1, 5'd8, 5'd3, 5'd2, 11'd2));   // AND r8,r3,r2
        put(32'h108, enc_r(6'd1, 5'd9, 5'd3, 5'd2, 11'd3));   // OR r9,r3,r2
        put(32'h10C, enc_r(6'd1, 5'd10, 5'd3, 5'd2, 11'd4));  // XOR r10,r3,r2
        put(32'h110, enc_i(6'd6, 5'd5, 5'd0, 16'h28));
        put(32'h114, enc_i(6'd6, 5'd8, 5'd0, 16'h2C));
        put(32'h118, enc_i(6'd6, 5'd9, 5'd0, 16'h30));
        put(32'h11C, enc_i(6'd6, 5'd10, 5'd0, 16'h34));
        put(32'h120, enc_i(6'd2, 5'd0, 5'd0, 16'h48));        // JMP self

        repeat (3) @(negedge clk);
        check("rst_imem_req", {31'b0, imem_req}, 32'd0);
        check("rst_imem_addr", imem_addr, 32'd0);
        check("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
        check("rst_retire", {31'b0, retire}, 32'd0);
        check("rst_illegal", {31'b0, illegal}, 32'd0);

        for (int a = 0; a <= 'h30; a += 4) fetch_q.push_back(a);
`ifdef MCPU_BRANCH_EN
        fetch_q.push_back(32'h2C);
        fetch_q.push_back(32'h30);
`endif
        for (int a = 'h34; a <= 'h44; a += 4) fetch_q.push_back(a);
        for (int a = 'h100; a <= 'h120; a += 4) fetch_q.push_back(a);

        push_ret(0, 4); push_ret(0, 4); push_ret(0, 4);
        push_ret(0, 8); push_ret(0, 8); push_ret(0, 8);
        push_ret(0, 4); push_ret(0, 8); push_ret(0, 4); push_ret(0, 8);
        push_ret(0, 4); push_ret(0, 4);
`ifdef MCPU_BRANCH_EN
        push_ret(0, 4); push_ret(0, 4); push_ret(0, 4);
`else
        push_ret(1, 4);
`endif
        push_ret(0, 8); push_ret(1, 4); push_ret(1, 4); push_ret(0, 8); push_ret(0, 4);
        for (int i = 0; i < 4; i++) push_ret(0, 4);
        for (int i = 0; i < 4; i++) push_ret(0, 8);

        push_dm(1, 32'h10, 32'd12, 1);
        push_dm(0, 32'h10, 32'd0, 0);
        push_dm(1, 32'h14, 32'd12, 1);
        push_dm(1, 32'h18, 32'hFFFF_FFFF, 1);
        push_dm(1, 32'h1C, 32'd0, 1);
`ifdef MCPU_BRANCH_EN
        push_dm(1, 32'h20, 32'd2, 1);
`else
        push_dm(1, 32'h20, 32'd1, 1);
`endif
        push_dm(1, 32'h24, 32'd12, 1);
        push_dm(1, 32'h28, 32'd8, 1);
        push_dm(1, 32'h2C, 32'd4, 1);
        push_dm(1, 32'h30, 32'd15, 1);
        push_dm(1, 32'h34, 32'd11, 1);

        reset = 1'b0;
        #1;
        check("req_before_reset_sampled", {31'b0, imem_req}, 32'd0);
        drain(3000);

        // Reset while an instruction fetch is stalled, then a stray ack before fetch restarts.
        imem_wait = 6;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(imem_req && icnt == 2) && n < 200);
        check("stall_reached", {31'b0, imem_req}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_imem_req", {31'b0, imem_req}, 32'd0);
        check("rst_mid_retire", {31'b0, retire}, 32'd0);
        @(negedge clk);
        imem_wait = 1;
        for (int a = 0; a <= 'h10; a += 4) fetch_q.push_back(a);
        push_ret(0, 5); push_ret(0, 5); push_ret(0, 5); push_ret(0, 9);
        push_dm(1, 32'h10, 32'd12, 1);
        reset      = 1'b0;
        force_iack = 1'b1;
        @(posedge clk);
        #1;
        force_iack = 1'b0;
        check("stray_ack_no_req", {31'b0, imem_req}, 32'd1);
        drain(1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
